memcopy_dispatch: RTL and testbench
===================================

MEMCOPY_DISPATCH -- requirements
Module: memcopy_dispatch

Interface
REQ-001 Parameter SRC_ADDR_SZ, default 14, SHALL set the width of source address and length.
REQ-002 Parameter DST_ADDR_SZ, default 14, SHALL set the width of destination address.
REQ-003 Parameter QUEUE_DEPTH, default 4, power of two ≥2, SHALL set the number of buffered copy requests.
REQ-004 clk  in  1  sole clock; reset  in  1  synchronous, active-high. One clock; reset is synchronous and active-high.
REQ-005 req_valid  in  1  producer offers a copy request.
REQ-006 req_ready  out  1  request queue can accept.
REQ-007 req_src_addr  in  SRC_ADDR_SZ  source start; req_dst_addr  in  DST_ADDR_SZ  destination start; req_len  in  SRC_ADDR_SZ  word count.
REQ-008 mc_activate  out  1  copy-engine start strobe.
REQ-009 mc_src_addr, mc_dst_addr, mc_src_len  out  SRC/DST/SRC widths  request presented to the copy engine.
REQ-010 mc_busy  in  1  copy-engine busy, registered by the engine one cycle after activate; high while the engine is in reset.
REQ-011 done  out  1  one-cycle pulse per completed or discarded request.
REQ-012 idle  out  1  queue empty and FSM in D_IDLE.

Function
REQ-013 A request SHALL be accepted on any edge where req_valid && req_ready; req_ready SHALL equal !full, with no push allowed while full even if a pop occurs that cycle.
REQ-014 Queue SHALL be FIFO-ordered; occupancy counter SHALL be clog2(QUEUE_DEPTH)+1 bits; pointers SHALL wrap modulo QUEUE_DEPTH.
REQ-015 FSM states SHALL be D_IDLE, D_ACTIVATE, D_WAIT_DONE.
REQ-016 D_IDLE, queue non-empty, head req_len==0: SHALL pop the head and pulse done the next cycle without asserting mc_activate; at most one discard per cycle.
REQ-017 D_IDLE, queue non-empty, head length non-zero, mc_busy==0: SHALL register head into mc_* outputs, set mc_activate=1, pop the head, go to D_ACTIVATE.
REQ-018 D_IDLE with mc_busy==1 SHALL NOT activate, regardless of queue contents.
REQ-019 D_ACTIVATE: mc_activate and mc_* SHALL hold stable until mc_busy is sampled 1, then mc_activate<=0 and go to D_WAIT_DONE.
REQ-020 D_WAIT_DONE: on mc_busy sampled 0, SHALL pulse done for one cycle and return to D_IDLE.
REQ-021 With the engine idle and queue empty, mc_activate SHALL rise on the second clock edge after the accepting edge.
REQ-022 mc_activate SHALL never be high in the cycle the engine returns busy low, preventing re-trigger.
REQ-023 A push and a pop SHALL be permitted on the same edge when not full; occupancy unchanged.

Reset
REQ-024 On reset: state=D_IDLE, queue empty, req_ready=0 during reset and 1 the cycle after, mc_activate=0, mc_src_addr/mc_dst_addr/mc_src_len=0, done=0, idle=1 after reset release.
REQ-025 Reset mid-copy SHALL discard all queued and in-flight requests without issuing done.

Configuration
REQ-026 Macro MEMCOPY_DISPATCH_STATS_EN, when defined, SHALL add outputs stat_copies[15:0] (incremented per D_WAIT_DONE completion) and stat_discards[15:0] (incremented per zero-length discard), both saturating at 16'hFFFF and cleared by reset.
REQ-027 Without MEMCOPY_DISPATCH_STATS_EN, those ports and counters SHALL be absent; all other behaviour identical.

Structure
REQ-028 Package memcopy_pkg SHALL hold copy_req_t (packed struct src_addr, dst_addr, len) and the dispatch state enum.
REQ-029 Queue SHALL be a sub-module copy_req_fifo (sync FIFO of copy_req_t, full/empty/push/pop); the FSM stays in memcopy_dispatch.

Verification
REQ-030 Single request src=0x010, dst=0x200, len=5, engine model busy 1 cycle after activate for 8 cycles -> activate on 2nd edge after accept, mc_* = 0x010/0x200/5, one done pulse after busy falls.
REQ-031 Push QUEUE_DEPTH+1 back-to-back requests while mc_busy held 1 -> req_ready low after 4 accepts, no activate; release busy -> four copies issued in order, four done pulses.
REQ-032 Zero-length request between two len=3 requests -> two activates only, three done pulses in order, stat_discards=1 when macro defined.
REQ-033 Hold mc_busy=1 for 10 cycles after reset with one queued request -> no activate until busy is 0.
REQ-034 Assert reset during D_WAIT_DONE with 2 queued -> mc_activate=0, idle=1, no done, no further activates after release.

Source files
------------

// File: rtl/memcopy_pkg.sv
// Shared types for the memcopy dispatcher: the queued copy request record
// and the dispatch FSM state encoding.
package memcopy_pkg;

  // Request fields are stored at a fixed maximum width so one record type
  // serves every parameterisation; address/length parameters must be <= 32.
  localparam int MC_FIELD_SZ = 32;

  typedef struct packed {
    logic [MC_FIELD_SZ-1:0] src_addr;
    logic [MC_FIELD_SZ-1:0] dst_addr;
    logic [MC_FIELD_SZ-1:0] len;
  } copy_req_t;

  typedef enum logic [1:0] {
    D_IDLE      = 2'd0,
    D_ACTIVATE  = 2'd1,
    D_WAIT_DONE = 2'd2
  } dispatch_state_t;

  // A zero-length request is retired without touching the copy engine.
  function automatic logic req_is_empty(input copy_req_t r);
    return (r.len == '0);
  endfunction

endpackage

// File: rtl/memcopy_dispatch_fifo.sv
// copy_req_fifo: synchronous FIFO of copy requests for the dispatcher.
// Storage is an inferred RAM with a registered head read. An entry becomes
// visible at the head (head_valid) one cycle after it is written, and a pop
// immediately presents the next stored entry on the following cycle.
module copy_req_fifo
  import memcopy_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  copy_req_t push_data,
  output logic      full,
  output logic      empty,
  input  logic      pop,
  output logic      head_valid,
  output copy_req_t head_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  copy_req_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_next;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             head_valid_reg;
  copy_req_t        head_reg;
  logic             push_ok;
  logic             pop_ok;

  // A full queue refuses pushes even when a pop happens on the same edge.
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && head_valid_reg;

  assign rd_ptr_next = rd_ptr_reg + PTR_W'(pop_ok);
  assign count_next  = count_reg + CNT_W'(push_ok) - CNT_W'(pop_ok);

  assign head_valid = head_valid_reg;
  assign head_data  = head_reg;

  // Storage write port.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Registered read of the entry that will be at the head after this edge.
  always_ff @(posedge clk) begin
    head_reg <= mem[rd_ptr_next];
  end

  // Pointers, occupancy and head-valid flag; only entries already written
  // before this edge can be the registered head.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      head_valid_reg <= 1'b0;
    end else begin
      wr_ptr_reg     <= wr_ptr_reg + PTR_W'(push_ok);
      rd_ptr_reg     <= rd_ptr_next;
      count_reg      <= count_next;
      head_valid_reg <= ((count_reg - CNT_W'(pop_ok)) != '0);
    end
  end

endmodule

// File: rtl/memcopy_dispatch.sv
// memcopy_dispatch: queues copy requests and hands them one at a time to a
// copy engine via an activate/busy handshake. Zero-length requests are
// retired with a done pulse and never reach the engine.
// Optional build macro MEMCOPY_DISPATCH_STATS_EN adds saturating
// stat_copies / stat_discards counters.
module memcopy_dispatch
  import memcopy_pkg::*;
#(
  parameter int SRC_ADDR_SZ = 14,
  parameter int DST_ADDR_SZ = 14,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [SRC_ADDR_SZ-1:0] req_src_addr,
  input  logic [DST_ADDR_SZ-1:0] req_dst_addr,
  input  logic [SRC_ADDR_SZ-1:0] req_len,
  output logic                   mc_activate,
  output logic [SRC_ADDR_SZ-1:0] mc_src_addr,
  output logic [DST_ADDR_SZ-1:0] mc_dst_addr,
  output logic [SRC_ADDR_SZ-1:0] mc_src_len,
  input  logic                   mc_busy,
  output logic                   done,
  output logic                   idle
`ifdef MEMCOPY_DISPATCH_STATS_EN
  ,
  output logic [15:0]            stat_copies,
  output logic [15:0]            stat_discards
`endif
);

  dispatch_state_t        state_reg, state_next;
  logic                   mc_activate_reg, mc_activate_next;
  logic [SRC_ADDR_SZ-1:0] mc_src_addr_reg, mc_src_addr_next;
  logic [DST_ADDR_SZ-1:0] mc_dst_addr_reg, mc_dst_addr_next;
  logic [SRC_ADDR_SZ-1:0] mc_src_len_reg, mc_src_len_next;
  logic                   done_reg, done_next;

  copy_req_t push_req;
  copy_req_t head_req;
  logic      fifo_full;
  logic      fifo_empty;
  logic      fifo_pop;
  logic      head_valid;
  logic      head_len_zero;

  assign push_req.src_addr = MC_FIELD_SZ'(req_src_addr);
  assign push_req.dst_addr = MC_FIELD_SZ'(req_dst_addr);
  assign push_req.len      = MC_FIELD_SZ'(req_len);

  copy_req_fifo #(
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (req_valid),
    .push_data  (push_req),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .pop        (fifo_pop),
    .head_valid (head_valid),
    .head_data  (head_req)
  );

  assign head_len_zero = req_is_empty(head_req);

  // Ready is held low while reset is asserted, so nothing is accepted then.
  assign req_ready   = !fifo_full && !reset;
  assign idle        = fifo_empty && (state_reg == D_IDLE);
  assign mc_activate = mc_activate_reg;
  assign mc_src_addr = mc_src_addr_reg;
  assign mc_dst_addr = mc_dst_addr_reg;
  assign mc_src_len  = mc_src_len_reg;
  assign done        = done_reg;

  // Dispatch FSM next-state and output decode.
  always_comb begin
    state_next       = state_reg;
    mc_activate_next = mc_activate_reg;
    mc_src_addr_next = mc_src_addr_reg;
    mc_dst_addr_next = mc_dst_addr_reg;
    mc_src_len_next  = mc_src_len_reg;
    done_next        = 1'b0;
    fifo_pop         = 1'b0;
    case (state_reg)
      D_IDLE: begin
        if (head_valid) begin
          if (head_len_zero) begin
            // Retire an empty request; engine busy state is irrelevant.
            fifo_pop  = 1'b1;
            done_next = 1'b1;
          end else if (!mc_busy) begin
            fifo_pop         = 1'b1;
            mc_activate_next = 1'b1;
            mc_src_addr_next = SRC_ADDR_SZ'(head_req.src_addr);
            mc_dst_addr_next = DST_ADDR_SZ'(head_req.dst_addr);
            mc_src_len_next  = SRC_ADDR_SZ'(head_req.len);
            state_next       = D_ACTIVATE;
          end
        end
      end
      D_ACTIVATE: begin
        // Hold the request until the engine acknowledges with busy.
        if (mc_busy) begin
          mc_activate_next = 1'b0;
          state_next       = D_WAIT_DONE;
        end
      end
      D_WAIT_DONE: begin
        // Activate is already low here, so a falling busy cannot re-trigger.
        if (!mc_busy) begin
          done_next  = 1'b1;
          state_next = D_IDLE;
        end
      end
      default: begin
        state_next = D_IDLE;
      end
    endcase
  end

  // Dispatch FSM state and registered engine-facing outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= D_IDLE;
      mc_activate_reg <= 1'b0;
      mc_src_addr_reg <= '0;
      mc_dst_addr_reg <= '0;
      mc_src_len_reg  <= '0;
      done_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      mc_activate_reg <= mc_activate_next;
      mc_src_addr_reg <= mc_src_addr_next;
      mc_dst_addr_reg <= mc_dst_addr_next;
      mc_src_len_reg  <= mc_src_len_next;
      done_reg        <= done_next;
    end
  end

`ifdef MEMCOPY_DISPATCH_STATS_EN
  logic [15:0] stat_copies_reg;
  logic [15:0] stat_discards_reg;
  logic        copy_evt;
  logic        discard_evt;

  assign copy_evt      = (state_reg == D_WAIT_DONE) && !mc_busy;
  assign discard_evt   = (state_reg == D_IDLE) && head_valid && head_len_zero;
  assign stat_copies   = stat_copies_reg;
  assign stat_discards = stat_discards_reg;

  // Saturating completion and discard counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_copies_reg   <= '0;
      stat_discards_reg <= '0;
    end else begin
      if (copy_evt && (stat_copies_reg != 16'hFFFF)) begin
        stat_copies_reg <= stat_copies_reg + 16'd1;
      end
      if (discard_evt && (stat_discards_reg != 16'hFFFF)) begin
        stat_discards_reg <= stat_discards_reg + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_memcopy_dispatch.sv
// Scoreboard bench for memcopy_dispatch with a simple copy-engine model.
module tb_memcopy_dispatch;

  localparam int SA = 14;
  localparam int DA = 14;
  localparam int QD = 4;
  localparam int ENG_BUSY = 8;

  typedef struct packed {
    logic [SA-1:0] src;
    logic [DA-1:0] dst;
    logic [SA-1:0] len;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [SA-1:0] req_src_addr;
  logic [DA-1:0] req_dst_addr;
  logic [SA-1:0] req_len;
  logic          mc_activate;
  logic [SA-1:0] mc_src_addr;
  logic [DA-1:0] mc_dst_addr;
  logic [SA-1:0] mc_src_len;
  logic          mc_busy;
  logic          done;
  logic          idle;
`ifdef MEMCOPY_DISPATCH_STATS_EN
  logic [15:0]   stat_copies;
  logic [15:0]   stat_discards;
`endif

  int tests = 0;
  int fails = 0;
  int act_total = 0;
  int done_total = 0;
  int act_since_done = 0;
  logic act_prev = 1'b0;
  logic eng_hold = 1'b0;
  int eng_cnt = 0;

  exp_t exp_act[$];
  int   exp_done[$];

  memcopy_dispatch #(
    .SRC_ADDR_SZ (SA),
    .DST_ADDR_SZ (DA),
    .QUEUE_DEPTH (QD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_src_addr (req_src_addr),
    .req_dst_addr (req_dst_addr),
    .req_len      (req_len),
    .mc_activate  (mc_activate),
    .mc_src_addr  (mc_src_addr),
    .mc_dst_addr  (mc_dst_addr),
    .mc_src_len   (mc_src_len),
    .mc_busy      (mc_busy),
    .done         (done),
    .idle         (idle)
`ifdef MEMCOPY_DISPATCH_STATS_EN
    ,
    .stat_copies  (stat_copies),
    .stat_discards(stat_discards)
`endif
  );

  always #5 clk = ~clk;

  // Copy-engine model: busy registered one cycle after activate, held
  // ENG_BUSY cycles; busy while in reset or while forced by eng_hold.
  always @(posedge clk) begin
    if (reset || eng_hold) begin
      mc_busy <= 1'b1;
      eng_cnt <= 0;
    end else if (eng_cnt > 0) begin
      eng_cnt <= eng_cnt - 1;
    end else if (mc_activate && !mc_busy) begin
      mc_busy <= 1'b1;
      eng_cnt <= ENG_BUSY - 1;
    end else begin
      mc_busy <= 1'b0;
    end
  end

  // Monitor: pops the scoreboard on every activate rise and done pulse.
  always @(posedge clk) begin
    #1;
    if (done) done_total++;
    if (mc_activate && !act_prev) act_total++;
    if (reset) begin
      exp_act.delete();
      exp_done.delete();
      act_since_done = 0;
    end else begin
      if (mc_activate && !act_prev) begin
        act_since_done++;
        tests++;
        if (exp_act.size() == 0) begin
          fails++;
          $display("FAIL unexpected_activate: src=%0h dst=%0h len=%0d, none expected",
                   mc_src_addr, mc_dst_addr, mc_src_len);
        end else begin
          exp_t e;
          e = exp_act.pop_front();
          if ({mc_src_addr, mc_dst_addr, mc_src_len} !== e) begin
            fails++;
            $display("FAIL activate_req: got src=%0h dst=%0h len=%0d, expected src=%0h dst=%0h len=%0d",
                     mc_src_addr, mc_dst_addr, mc_src_len, e.src, e.dst, e.len);
          end else begin
            $display("[TB] activate src=%0h dst=%0h len=%0d ok", e.src, e.dst, e.len);
          end
        end
      end
      if (done) begin
        tests++;
        if (exp_done.size() == 0) begin
          fails++;
          $display("FAIL unexpected_done: got done=1, expected no done");
        end else begin
          int k;
          k = exp_done.pop_front();
          if (act_since_done != k) begin
            fails++;
            $display("FAIL done_kind: got %0d activates before done, expected %0d", act_since_done, k);
          end else begin
            $display("[TB] done (%0s) ok", (k != 0) ? "copy" : "discard");
          end
        end
        act_since_done = 0;
      end
    end
    act_prev = mc_activate;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("[TB] %s = %0h ok", name, act);
    end
  endtask

  task automatic send(input logic [SA-1:0] s, input logic [DA-1:0] d, input logic [SA-1:0] l);
    int t;
    @(negedge clk);
    req_valid    = 1'b1;
    req_src_addr = s;
    req_dst_addr = d;
    req_len      = l;
    t = 0;
    while (!req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got req_ready=0 after %0d cycles, expected 1", t);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (l != 0) exp_act.push_back({s, d, l});
    exp_done.push_back((l != 0) ? 1 : 0);
  endtask

  task automatic wait_idle(input int budget);
    int t;
    t = 0;
    while (!(idle && exp_done.size() == 0 && exp_act.size() == 0) && t < budget) begin
      @(posedge clk);
      #2;
      t++;
    end
    if (t >= budget) begin
      tests++;
      fails++;
      $display("FAIL wait_idle: got idle=%0d pending=%0d after %0d cycles, expected drained",
               idle, exp_done.size(), t);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset     = 1'b1;
    req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    check("rst_ready_low", {31'd0, req_ready}, 32'd0);
    check("rst_activate_low", {31'd0, mc_activate}, 32'd0);
    check("rst_done_low", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_idle", {31'd0, idle}, 32'd1);
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);
    check("post_rst_src_addr", 32'(mc_src_addr), 32'd0);
  endtask

  // Global time bound so the bench always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // Directed stimulus.
  initial begin
    int a0;
    int d0;
    int t;
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_src_addr = '0;
    req_dst_addr = '0;
    req_len      = '0;

    // Reset state.
    do_reset(3);
    check("post_rst_activate", {31'd0, mc_activate}, 32'd0);
    check("post_rst_dst_addr", 32'(mc_dst_addr), 32'd0);
    check("post_rst_len", 32'(mc_src_len), 32'd0);
    check("post_rst_done", {31'd0, done}, 32'd0);
`ifdef MEMCOPY_DISPATCH_STATS_EN
    check("post_rst_stat_copies", {16'd0, stat_copies}, 32'd0);
`endif

    // Single request: activate on the second edge after accept.
    repeat (2) @(negedge clk);
    d0 = done_total;
    send(14'h010, 14'h200, 14'd5);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 check("lat_edge1_activate", {31'd0, mc_activate}, 32'd0);
    check("lat_edge1_idle", {31'd0, idle}, 32'd0);
    @(posedge clk);
    #1 check("lat_edge2_activate", {31'd0, mc_activate}, 32'd1);
    wait_idle(100);
    check("single_done_count", 32'(done_total - d0), 32'd1);

    // Fill the queue while the engine is busy; a fifth request is refused.
    eng_hold = 1'b1;
    @(posedge clk);
    a0 = act_total;
    d0 = done_total;
    for (int i = 0; i < QD; i++) begin
      send(SA'(14'h100 + i * 16), DA'(14'h400 + i * 16), SA'(i + 1));
    end
    @(negedge clk);
    req_src_addr = 14'h1FF;
    req_dst_addr = 14'h3FF;
    req_len      = 14'd9;
    check("full_ready_low", {31'd0, req_ready}, 32'd0);
    repeat (6) @(posedge clk);
    #1 check("full_ready_still_low", {31'd0, req_ready}, 32'd0);
    check("busy_hold_no_activate", 32'(act_total - a0), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    eng_hold  = 1'b0;
    wait_idle(400);
    check("fill_activates", 32'(act_total - a0), 32'd4);
    check("fill_dones", 32'(done_total - d0), 32'd4);

    // Busy held after reset blocks activation until it drops.
    eng_hold = 1'b1;
    do_reset(2);
    send(14'h3A0, 14'h1C0, 14'd2);
    #1 req_valid = 1'b0;
    a0 = act_total;
    repeat (10) @(posedge clk);
    #1 check("busy_after_rst_no_activate", 32'(act_total - a0), 32'd0);
    @(negedge clk);
    eng_hold = 1'b0;
    wait_idle(100);
    check("busy_release_activates", 32'(act_total - a0), 32'd1);

    // Reset while waiting for completion with two requests still queued.
    a0 = act_total;
    send(14'h050, 14'h150, 14'd3);
    send(14'h060, 14'h160, 14'd3);
    send(14'h070, 14'h170, 14'd3);
    #1 req_valid = 1'b0;
    t = 0;
    while (!(mc_busy && !mc_activate && (act_total - a0) == 1) && t < 50) begin
      @(posedge clk);
      #2;
      t++;
    end
    check("reached_wait_done", {31'd0, (t < 50)}, 32'd1);
    check("midcopy_not_idle", {31'd0, idle}, 32'd0);
    a0 = act_total;
    d0 = done_total;
    do_reset(2);
    repeat (30) @(posedge clk);
    #1 check("post_rst_no_activate", 32'(act_total - a0), 32'd0);
    check("post_rst_no_done", 32'(done_total - d0), 32'd0);
    check("post_rst_window_idle", {31'd0, idle}, 32'd1);

    // Zero-length request between two copies is discarded in order.
    a0 = act_total;
    d0 = done_total;
    send(14'h100, 14'h300, 14'd3);
    send(14'h111, 14'h311, 14'd0);
    send(14'h120, 14'h320, 14'd3);
    #1 req_valid = 1'b0;
    wait_idle(300);
    check("zero_len_activates", 32'(act_total - a0), 32'd2);
    check("zero_len_dones", 32'(done_total - d0), 32'd3);
`ifdef MEMCOPY_DISPATCH_STATS_EN
    check("stat_discards", {16'd0, stat_discards}, 32'd1);
    check("stat_copies", {16'd0, stat_copies}, 32'd2);
`endif

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
